// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial adder/subtractor reusing one full-adder cell.
// Operands are latched on start and processed LSB first, one bit per clock.
// Optional macro SERIAL_ADDSUB_OVF_EN adds a signed-overflow output (ovf).
module serial_addsub #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
`ifdef SERIAL_ADDSUB_OVF_EN
  output logic             ovf,
`endif
  output logic             co
);

  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] result_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             mode_q, mode_d;
  logic             co_d;
  logic             s_bit;
  logic             carry_next;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic             ovf_d;
`endif

  // Single full-adder cell working on the current LSBs and the carry flop
  always_comb begin
    s_bit      = op_a_q[0] ^ op_b_q[0] ^ carry_q;
    carry_next = (op_a_q[0] & op_b_q[0]) | (op_a_q[0] & carry_q) | (op_b_q[0] & carry_q);
  end

  // Status decoded from the state register only
  always_comb begin
    ready = (state_q == S_IDLE);
    done  = (state_q == S_DONE);
  end

  // Next-state and datapath next values
  always_comb begin
    state_d  = state_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    sum_d    = sum_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    mode_d   = mode_q;
    result_d = result;
    co_d     = co;
`ifdef SERIAL_ADDSUB_OVF_EN
    ovf_d    = ovf;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_a_d  = a;
          op_b_d  = sub ? ~b : b;
          carry_d = sub;
          mode_d  = sub;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        op_a_d  = {1'b0, op_a_q[WIDTH-1:1]};
        op_b_d  = {1'b0, op_b_q[WIDTH-1:1]};
        sum_d   = {s_bit, sum_q[WIDTH-1:1]};
        carry_d = carry_next;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          result_d = {s_bit, sum_q[WIDTH-1:1]};
          co_d     = mode_q ? ~carry_next : carry_next;
`ifdef SERIAL_ADDSUB_OVF_EN
          // carry into the MSB is the flop value on this final bit
          ovf_d    = carry_q ^ carry_next;
`endif
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a_q  <= '0;
      op_b_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      mode_q  <= 1'b0;
      result  <= '0;
      co      <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
      ovf     <= 1'b0;
`endif
    end else begin
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      mode_q  <= mode_d;
      result  <= result_d;
      co      <= co_d;
`ifdef SERIAL_ADDSUB_OVF_EN
      ovf     <= ovf_d;
`endif
    end
  end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Bit-serial adder/subtractor built around a single full-adder cell and a carry/borrow flip-flop.
- Latches two WIDTH-bit operands on a start handshake and processes one bit per clock, LSB first.
- Presents the registered result with carry-out, or borrow in subtract mode.
- Serves as the sequential, area-minimal arithmetic unit for datapaths where one adder cell is reused over time.

Parameters:
- WIDTH, 8, operand and result width in bits (>= 2).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; accepted only when ready=1
- sub  input  1  0: A+B, 1: A-B; sampled with start
- a  input  WIDTH  operand A; sampled with start
- b  input  WIDTH  operand B; sampled with start
- ready  output  1  1 in IDLE; unit can accept start
- done  output  1  one-cycle pulse; result/co valid
- result  output  WIDTH  registered sum/difference
- co  output  1  add: carry-out; sub: borrow (1 when A < B unsigned)

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, ready=1, done=0, result=0, co=0.
  - Shift registers, bit counter and carry flop all cleared.
  - Reset takes effect immediately, including mid-operation; the in-flight operation is discarded.
- States:
  - IDLE: ready=1. If start=1 at a clock edge:
    - load opA=a and opB=(sub ? ~b : b).
    - carry=sub (two's-complement subtract), cnt=0, latch mode.
    - go to RUN.
  - RUN: ready=0. Each edge:
    - s = opA[0]^opB[0]^carry; carry = majority(opA[0], opB[0], carry).
    - shift opA and opB right by 1; shift s into the MSB of the internal sum register.
    - cnt++.
    - On the edge where cnt==WIDTH-1:
      - copy the final sum register into result.
      - co = mode_sub ? ~carry_next : carry_next.
      - go to DONE.
  - DONE: done=1, ready=0 for exactly one cycle, then IDLE unconditionally.
- Latency:
  - start sampled at edge E0; done is high in the cycle after edge E0+WIDTH.
  - Throughput is one operation per WIDTH+2 cycles when start is held high.
- result and co change only on the completing edge; they hold their previous values during RUN, DONE and IDLE.
- start while ready=0 is ignored, with no queuing. sub/a/b changes during RUN have no effect.
- start held continuously: a new operation is accepted on the first IDLE cycle after DONE.
- Width rules:
  - result is modulo 2^WIDTH.
  - The carry flop is 1 bit.
  - cnt is sized to hold WIDTH-1.
- No X propagation: every register has a reset value; done and ready are derived from state only.

Optional Feature:
- Macro: SERIAL_ADDSUB_OVF_EN
- Defined:
  - adds output port ovf (1 bit), reset 0.
  - Updated on the completing edge together with result.
  - ovf = carry into MSB XOR carry out of MSB, i.e. signed two's-complement overflow for the selected operation.
  - Holds its value until the next completion.
- Undefined:
  - port ovf does not exist.
  - No extra logic; all other behaviour is identical.

Test Plan (WIDTH=8):
- Add: a=0x35, b=0x4A, sub=0 -> done 9 edges after the start edge, result=0x7F, co=0; ready low through RUN/DONE.
- Add wrap: a=0xFF, b=0x01, sub=0 -> result=0x00, co=1.
- Subtract: a=0x10, b=0x01, sub=1 -> result=0x0F, co=0.
- Subtract borrow: a=0x00, b=0x01, sub=1 -> result=0xFF, co=1.
- Busy/reset: start a=0x12, b=0x34; pulse start with a=0xAA, b=0xAA on cycle 3 -> ignored, result=0x46. Then start again and assert rst_n=0 on cycle 4 -> immediately ready=1, done=0, result=0, co=0; no done pulse follows.
- With SERIAL_ADDSUB_OVF_EN:
  - a=0x7F, b=0x01, sub=0 -> result=0x80, co=0, ovf=1.
  - a=0x80, b=0x01, sub=1 -> result=0x7F, co=0, ovf=1.
  - a=0x05, b=0x03, sub=0 -> ovf=0.
